// File: rtl/pipeline_pkg.sv
// Shared state and occupancy encodings for the two-entry elastic pipeline stage.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      BUSY:    occ_of = OCC_BUSY;
      FULL:    occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipeline_register.sv
// Two-entry elastic stage (main + skid); one-cycle latency, strict FIFO order.
// Backpressure: registered inReady drops only when both entries are held, so outReady never reaches inReady combinationally.
module elastic_pipeline_register
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  input  logic [DATA_WIDTH-1:0]  inData,
  output logic                   inReady,
  output logic                   outValid,
  output logic [DATA_WIDTH-1:0]  outData,
  input  logic                   outReady,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] stallCount
);

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  main_q, main_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;
  logic                   in_ready_q, in_ready_d;
  logic                   xfer_in, xfer_out;

  assign outValid   = (state_q != EMPTY);
  assign outData    = main_q;
  assign occupancy  = occ_of(state_q);
  assign inReady    = in_ready_q;
  assign stallCount = stall_q;

  assign xfer_in  = inValid & in_ready_q;
  assign xfer_out = outValid & outReady;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    // Stall cycles are counted regardless of flush, saturating at all-ones.
    if (outValid && !outReady && (stall_q != {COUNT_WIDTH{1'b1}}))
      stall_d = stall_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d = BUSY;
            main_d  = inData;
          end
        end
        BUSY: begin
          if (xfer_in && xfer_out) begin
            main_d = inData;
          end else if (xfer_in) begin
            state_d = FULL;
            skid_d  = inData;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      stall_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      stall_q    <= stall_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
